// File: rtl/sqrt_chain_seq_if.sv
// Handshake bundle between the square-root sequencer and the converter/core chain.
// The sequencer takes the master modport; the datapath side (or a bench) takes the slave modport.
interface sqrt_chain_seq_if;
   logic        ce1ms;
   logic [31:0] X;
   logic        ok_bin;
   logic        ok_sqrt;
   logic        ok_dec;
   logic [31:0] Y_dec;
   logic        st_bin;
   logic        st_sqrt;
   logic        st_dec;
   logic [31:0] X_op;
   logic [31:0] Y;
   logic        busy;
   logic        valid;
   logic        err_tmo;
   logic        err_bcd;

   modport master (
      input  ce1ms, X, ok_bin, ok_sqrt, ok_dec, Y_dec,
      output st_bin, st_sqrt, st_dec, X_op, Y, busy, valid, err_tmo, err_bcd
   );

   modport slave (
      output ce1ms, X, ok_bin, ok_sqrt, ok_dec, Y_dec,
      input  st_bin, st_sqrt, st_dec, X_op, Y, busy, valid, err_tmo, err_bcd
   );
endinterface

// File: rtl/sqrt_chain_seq.sv
// Paces DEC8->BIN27, the square-root core and BIN27->DEC8 with one-cycle start strobes,
// runs only on a changed legal BCD operand, and aborts any stage that exceeds TMO_CYC cycles.
module sqrt_chain_seq #(
   parameter int TMO_CYC = 4096,
   parameter int TMO_W   = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   sqrt_chain_seq_if.master bus
);

   typedef enum logic [2:0] {IDLE, S_BIN, S_SQRT, S_DEC, ERR} state_t;

   state_t             state_q, state_d;
   logic [31:0]        x_op_q, x_op_d;
   logic [31:0]        y_q, y_d;
   logic               st_bin_q, st_bin_d;
   logic               st_sqrt_q, st_sqrt_d;
   logic               st_dec_q, st_dec_d;
   logic               valid_q, valid_d;
   logic               err_tmo_q, err_tmo_d;
   logic               err_bcd_q, err_bcd_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;

   logic [7:0]         nib_bad;
   logic               x_legal;
   logic               tmo_last;
   logic               need_run;

   for (genvar gi = 0; gi < 8; gi++) begin : g_nib
      assign nib_bad[gi] = (bus.X[4*gi+3 -: 4] > 4'd9);
   end

   assign x_legal  = ~|nib_bad;
   assign tmo_last = (tmo_q == TMO_W'(TMO_CYC - 1));
   // The very first run after reset must start even when X equals the reset value of X_op.
   assign need_run = (bus.X != x_op_q) || (!valid_q && !err_tmo_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         x_op_q    <= '0;
         y_q       <= '0;
         st_bin_q  <= 1'b0;
         st_sqrt_q <= 1'b0;
         st_dec_q  <= 1'b0;
         valid_q   <= 1'b0;
         err_tmo_q <= 1'b0;
         err_bcd_q <= 1'b0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         x_op_q    <= x_op_d;
         y_q       <= y_d;
         st_bin_q  <= st_bin_d;
         st_sqrt_q <= st_sqrt_d;
         st_dec_q  <= st_dec_d;
         valid_q   <= valid_d;
         err_tmo_q <= err_tmo_d;
         err_bcd_q <= err_bcd_d;
         tmo_q     <= tmo_d;
      end
   end

   // An ok arriving while the stage's own strobe is still high belongs to the previous run.
   always_comb begin
      state_d   = state_q;
      x_op_d    = x_op_q;
      y_d       = y_q;
      st_bin_d  = 1'b0;
      st_sqrt_d = 1'b0;
      st_dec_d  = 1'b0;
      valid_d   = valid_q;
      err_tmo_d = err_tmo_q;
      err_bcd_d = err_bcd_q;
      tmo_d     = tmo_q + TMO_W'(1);
      case (state_q)
         IDLE, ERR: begin
            tmo_d = '0;
            if (bus.ce1ms) begin
               if (!x_legal) begin
                  err_bcd_d = 1'b1;
               end else begin
                  err_bcd_d = 1'b0;
                  if (need_run) begin
                     x_op_d    = bus.X;
                     valid_d   = 1'b0;
                     err_tmo_d = 1'b0;
                     st_bin_d  = 1'b1;
                     state_d   = S_BIN;
                  end
               end
            end
         end
         S_BIN: begin
            if (bus.ok_bin && !st_bin_q) begin
               st_sqrt_d = 1'b1;
               tmo_d     = '0;
               state_d   = S_SQRT;
            end else if (tmo_last) begin
               err_tmo_d = 1'b1;
               valid_d   = 1'b0;
               state_d   = ERR;
            end
         end
         S_SQRT: begin
            if (bus.ok_sqrt && !st_sqrt_q) begin
               st_dec_d = 1'b1;
               tmo_d    = '0;
               state_d  = S_DEC;
            end else if (tmo_last) begin
               err_tmo_d = 1'b1;
               valid_d   = 1'b0;
               state_d   = ERR;
            end
         end
         S_DEC: begin
            if (bus.ok_dec && !st_dec_q) begin
               y_d     = bus.Y_dec;
               valid_d = 1'b1;
               tmo_d   = '0;
               state_d = IDLE;
            end else if (tmo_last) begin
               err_tmo_d = 1'b1;
               valid_d   = 1'b0;
               state_d   = ERR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.st_bin  = st_bin_q;
   assign bus.st_sqrt = st_sqrt_q;
   assign bus.st_dec  = st_dec_q;
   assign bus.X_op    = x_op_q;
   assign bus.Y       = y_q;
   assign bus.busy    = (state_q == S_BIN) || (state_q == S_SQRT) || (state_q == S_DEC);
   assign bus.valid   = valid_q;
   assign bus.err_tmo = err_tmo_q;
   assign bus.err_bcd = err_bcd_q;

endmodule

// File: tb/tb_sqrt_chain_seq.sv
// Bench for sqrt_chain_seq: the bench plays the three datapath stages and scoreboards each result.
module tb_sqrt_chain_seq;

   logic clk;
   logic rst_n;

   sqrt_chain_seq_if bus ();

   sqrt_chain_seq #(.TMO_CYC(16), .TMO_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int n_bin = 0;
   int n_sqrt = 0;
   int n_dec = 0;
   int n_multi = 0;
   int cyc_cnt = 0;
   logic [31:0] exp_q[$];

   always @(negedge clk) begin
      cyc_cnt++;
      if (bus.st_bin)  n_bin++;
      if (bus.st_sqrt) n_sqrt++;
      if (bus.st_dec)  n_dec++;
      if ((32'(bus.st_bin) + 32'(bus.st_sqrt) + 32'(bus.st_dec)) > 1) n_multi++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   function automatic int from_bcd(input logic [31:0] b);
      int r = 0;
      for (int i = 7; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
      return r;
   endfunction

   function automatic int isqrt(input int v);
      int r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r = '0;
      int t = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic strobe(input int k);
      if (k == 0) return bus.st_bin;
      if (k == 1) return bus.st_sqrt;
      return bus.st_dec;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic tick(input logic [31:0] x);
      bus.X = x;
      bus.ce1ms = 1'b1;
      step();
      bus.ce1ms = 1'b0;
   endtask

   task automatic start_run(input logic [31:0] x, input bit push);
      if (push) exp_q.push_back(to_bcd(isqrt(from_bcd(x))));
      tick(x);
   endtask

   task automatic wait_strobe(input int k, input string tag, output int c);
      c = 0;
      while (!strobe(k) && c < 200) begin
         step();
         c++;
      end
      chk(tag, 32'(strobe(k)), 32'd1);
   endtask

   // Stage model: the decimal converter returns the square root of whatever X_op the DUT holds.
   task automatic pulse(input int k);
      if (k == 0) bus.ok_bin = 1'b1;
      if (k == 1) bus.ok_sqrt = 1'b1;
      if (k == 2) begin
         bus.ok_dec = 1'b1;
         bus.Y_dec = to_bcd(isqrt(from_bcd(bus.X_op)));
      end
      step();
      bus.ok_bin = 1'b0;
      bus.ok_sqrt = 1'b0;
      bus.ok_dec = 1'b0;
   endtask

   task automatic stage(input int k, input int lat);
      int c;
      wait_strobe(k, (k == 0) ? "st_bin" : (k == 1) ? "st_sqrt" : "st_dec", c);
      repeat (lat) step();
      pulse(k);
   endtask

   task automatic finish_run(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         e = '0;
      end else begin
         e = exp_q.pop_front();
         chk(tag, bus.Y, e);
      end
      chk({tag, "_valid"}, 32'(bus.valid), 32'd1);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      $display("run %s: X_op=%h Y=%h expected=%h", tag, bus.X_op, bus.Y, e);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctl"}, 32'({bus.st_bin, bus.st_sqrt, bus.st_dec, bus.busy,
                               bus.valid, bus.err_tmo, bus.err_bcd}), 32'd0);
      chk({tag, "_xop"}, bus.X_op, 32'd0);
      chk({tag, "_y"}, bus.Y, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int t_bin;
      int snap;

      rst_n = 1'b0;
      bus.ce1ms = 1'b0;
      bus.X = '0;
      bus.ok_bin = 1'b0;
      bus.ok_sqrt = 1'b0;
      bus.ok_dec = 1'b0;
      bus.Y_dec = '0;
      repeat (3) step();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) step();

      // Basic run 0x144 -> 0x12 with latency measurement
      snap = n_bin;
      start_run(32'h0000_0144, 1'b1);
      wait_strobe(0, "st_bin_first", c);
      chk("st_bin_delay", 32'(c), 32'd0);
      chk("busy_with_st_bin", 32'(bus.busy), 32'd1);
      chk("xop_latch", bus.X_op, 32'h0000_0144);
      t_bin = cyc_cnt;
      repeat (3) step();
      pulse(0);
      stage(1, 5);
      stage(2, 2);
      chk("latency", 32'(cyc_cnt - t_bin), 32'd13);
      finish_run("r144");
      chk("strobes_once", 32'(n_bin - snap), 32'd1);
      chk("strobes_once_sd", 32'({n_sqrt, n_dec}), {32'd1, 32'd1});

      // Same operand: nothing restarts
      snap = n_bin + n_sqrt + n_dec;
      repeat (5) begin
         tick(32'h0000_0144);
         repeat (3) step();
      end
      chk("same_x_no_strobe", 32'(n_bin + n_sqrt + n_dec - snap), 32'd0);

      // Illegal BCD operand
      tick(32'h0000_0A00);
      repeat (2) step();
      chk("bcd_err", 32'(bus.err_bcd), 32'd1);
      chk("bcd_no_strobe", 32'(n_bin + n_sqrt + n_dec - snap), 32'd0);
      chk("bcd_y_hold", bus.Y, 32'h0000_0012);
      chk("bcd_valid_hold", 32'(bus.valid), 32'd1);
      chk("bcd_xop_hold", bus.X_op, 32'h0000_0144);

      // Timeout in S_SQRT
      start_run(32'h0000_0400, 1'b0);
      chk("bcd_err_clear", 32'(bus.err_bcd), 32'd0);
      stage(0, 2);
      wait_strobe(1, "st_sqrt_tmo", c);
      c = 0;
      while (!bus.err_tmo && c < 100) begin
         step();
         c++;
      end
      chk("tmo_cycles", 32'(c), 32'd16);
      chk("tmo_valid", 32'(bus.valid), 32'd0);
      chk("tmo_busy", 32'(bus.busy), 32'd0);
      chk("tmo_y_hold", bus.Y, 32'h0000_0012);
      $display("run tmo: X_op=%h err_tmo=%0d after %0d cycles", bus.X_op, bus.err_tmo, c);
      snap = n_bin + n_sqrt + n_dec;
      tick(32'h0000_0400);
      repeat (4) step();
      chk("err_no_retry", 32'(n_bin + n_sqrt + n_dec - snap), 32'd0);
      chk("err_tmo_kept", 32'(bus.err_tmo), 32'd1);
      start_run(32'h0000_0081, 1'b1);
      stage(0, 1);
      stage(1, 1);
      stage(2, 1);
      finish_run("r81");
      chk("err_tmo_clear", 32'(bus.err_tmo), 32'd0);

      // Operand changes mid-run
      start_run(32'h0000_0100, 1'b1);
      stage(0, 2);
      wait_strobe(1, "st_sqrt_mid", c);
      bus.X = 32'h0000_0049;
      bus.ce1ms = 1'b1;
      step();
      bus.ce1ms = 1'b0;
      step();
      pulse(1);
      stage(2, 1);
      finish_run("r100");
      chk("mid_xop_kept", bus.X_op, 32'h0000_0100);
      repeat (2) step();
      start_run(32'h0000_0049, 1'b1);
      stage(0, 1);
      stage(1, 2);
      stage(2, 3);
      finish_run("r49");

      // Stray oks during S_BIN
      start_run(32'h0000_0900, 1'b1);
      wait_strobe(0, "st_bin_stray", c);
      snap = n_sqrt;
      pulse(0);
      pulse(2);
      repeat (3) step();
      chk("stray_busy", 32'(bus.busy), 32'd1);
      chk("stray_no_sqrt", 32'(n_sqrt - snap), 32'd0);
      pulse(0);
      stage(1, 1);
      stage(2, 1);
      finish_run("r900");

      // Reset during S_DEC
      start_run(32'h0000_1600, 1'b0);
      stage(0, 1);
      stage(1, 1);
      wait_strobe(2, "st_dec_rst", c);
      step();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      step();
      rst_n = 1'b1;
      snap = n_bin + n_sqrt + n_dec;
      repeat (10) step();
      check_reset_outputs("rst_after");
      chk("rst_no_strobe", 32'(n_bin + n_sqrt + n_dec - snap), 32'd0);
      start_run(32'h0000_1600, 1'b1);
      stage(0, 1);
      stage(1, 1);
      stage(2, 1);
      finish_run("r1600");

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      chk("one_strobe_max", 32'(n_multi), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
